// File: rtl/sol32lsu.sv
// sol32lsu: turns core load/store requests into one or two word-aligned bus beats, splitting misaligned accesses
module sol32lsu (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [1:0]  DataWidth,
  input  logic [31:0] MemoryAddress,
  input  logic [31:0] DataOut,
  output logic [31:0] DataIn,
  output logic        Stall,
  output logic        Fault,
  output logic        BusRequest,
  output logic        BusWrite,
  output logic [31:0] BusAddress,
  output logic [3:0]  BusByteEnable,
  output logic [31:0] BusWriteData,
  input  logic [31:0] BusReadData,
  input  logic        BusReady,
  input  logic        BusError
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] dm_q, dm_d;
  logic [3:0]  lhi_q, lhi_d;
  logic [31:0] whi_q, whi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] data_in_q, data_in_d;
  logic        fault_q, fault_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wd_q, bus_wd_d;
  logic        req, bad;
  logic [3:0]  mask;
  logic [31:0] dmask, ld;
  logic [7:0]  lanes;
  logic [63:0] wvec, rvec, rsh;
  // lane/data placement for the incoming request and load extraction from returning beats
  always_comb begin
    req   = ReadEnable | WriteEnable;
    bad   = (ReadEnable & WriteEnable) | (DataWidth == 2'b11);
    mask  = DataWidth == 2'b00 ? 4'b0001 : DataWidth == 2'b01 ? 4'b0011 : 4'b1111;
    dmask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    lanes = {4'b0000, mask} << MemoryAddress[1:0];
    wvec  = {32'b0, DataOut & dmask} << {MemoryAddress[1:0], 3'b000};
    rvec  = state_q == BEAT1 ? {BusReadData, lo_q} : {32'b0, BusReadData};
    rsh   = rvec >> {off_q, 3'b000};
    ld    = rsh[31:0] & dm_q;
  end
  // next state and next registered outputs
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    dm_d       = dm_q;
    lhi_d      = lhi_q;
    whi_d      = whi_q;
    lo_d       = lo_q;
    data_in_d  = data_in_q;
    fault_d    = 1'b0;
    bus_req_d  = bus_req_q;
    bus_wr_d   = bus_wr_q;
    bus_addr_d = bus_addr_q;
    bus_be_d   = bus_be_q;
    bus_wd_d   = bus_wd_q;
    case (state_q)
      IDLE: begin
        if (req && bad) begin
          state_d   = DONE;
          fault_d   = 1'b1;
          data_in_d = '0;
        end else if (req) begin
          state_d    = BEAT0;
          off_d      = MemoryAddress[1:0];
          dm_d       = dmask;
          lhi_d      = lanes[7:4];
          whi_d      = wvec[63:32];
          bus_req_d  = 1'b1;
          bus_wr_d   = WriteEnable;
          bus_addr_d = {MemoryAddress[31:2], 2'b00};
          bus_be_d   = lanes[3:0];
          bus_wd_d   = wvec[31:0];
        end
      end
      BEAT0: begin
        if (BusReady) begin
          bus_req_d = 1'b0;
          lo_d      = BusReadData;
          if (BusError) begin
            state_d   = DONE;
            fault_d   = 1'b1;
            data_in_d = '0;
          end else if (lhi_q != 4'b0000) begin
            state_d    = BEAT1;
            bus_req_d  = 1'b1;
            bus_addr_d = bus_addr_q + 32'd4;
            bus_be_d   = lhi_q;
            bus_wd_d   = whi_q;
          end else begin
            state_d   = DONE;
            data_in_d = bus_wr_q ? '0 : ld;
          end
        end
      end
      BEAT1: begin
        if (BusReady) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
          fault_d   = BusError;
          data_in_d = (BusError | bus_wr_q) ? '0 : ld;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared by the active-low synchronous reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      off_q      <= '0;
      dm_q       <= '0;
      lhi_q      <= '0;
      whi_q      <= '0;
      lo_q       <= '0;
      data_in_q  <= '0;
      fault_q    <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_wr_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_be_q   <= '0;
      bus_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      dm_q       <= dm_d;
      lhi_q      <= lhi_d;
      whi_q      <= whi_d;
      lo_q       <= lo_d;
      data_in_q  <= data_in_d;
      fault_q    <= fault_d;
      bus_req_q  <= bus_req_d;
      bus_wr_q   <= bus_wr_d;
      bus_addr_q <= bus_addr_d;
      bus_be_q   <= bus_be_d;
      bus_wd_q   <= bus_wd_d;
    end
  end
  assign DataIn        = data_in_q;
  assign Fault         = fault_q;
  assign BusRequest    = bus_req_q;
  assign BusWrite      = bus_wr_q;
  assign BusAddress    = bus_addr_q;
  assign BusByteEnable = bus_be_q;
  assign BusWriteData  = bus_wd_q;
  assign Stall         = Reset & req & (state_q != DONE);
endmodule

// File: tb/tb_sol32lsu.sv
// tb_sol32lsu: directed and random load/store transactions against a byte-level model of the access
module tb_sol32lsu;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        ReadEnable = 1'b0;
  logic        WriteEnable = 1'b0;
  logic [1:0]  DataWidth = 2'b00;
  logic [31:0] MemoryAddress = '0;
  logic [31:0] DataOut = '0;
  logic [31:0] BusReadData = '0;
  logic        BusReady = 1'b0;
  logic        BusError = 1'b0;
  logic [31:0] DataIn, BusAddress, BusWriteData;
  logic        Stall, Fault, BusRequest, BusWrite;
  logic [3:0]  BusByteEnable;
  int nvec = 0;
  int nerr = 0;
  logic [31:0] mem [logic [31:0]];

  sol32lsu dut (
    .Clock(Clock), .Reset(Reset), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
    .DataWidth(DataWidth), .MemoryAddress(MemoryAddress), .DataOut(DataOut), .DataIn(DataIn),
    .Stall(Stall), .Fault(Fault), .BusRequest(BusRequest), .BusWrite(BusWrite),
    .BusAddress(BusAddress), .BusByteEnable(BusByteEnable), .BusWriteData(BusWriteData),
    .BusReadData(BusReadData), .BusReady(BusReady), .BusError(BusError)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdword(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  function automatic logic [7:0] rdbyte(input logic [31:0] b);
    logic [31:0] t;
    t = rdword({b[31:2], 2'b00});
    return t[8*int'(b[1:0]) +: 8];
  endfunction

  // one access: model the touched bytes, act as bus slave, check beats, latency and result
  task automatic txn(input logic re, input logic we, input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] d, input int waits, input int errb);
    int n, nb, nbe, eb, cyc, bi, wc, expcyc, ln;
    int wt[2];
    logic [31:0] eaddr[2];
    logic [31:0] ewd[2];
    logic [3:0]  ebe[2];
    logic [31:0] ba, eload;
    logic bad, efault;
    n = w == 2'd0 ? 1 : w == 2'd1 ? 2 : 4;
    bad = (re && we) || w == 2'd3;
    nb = 0;
    eload = '0;
    for (int i = 0; i < 2; i++) begin
      eaddr[i] = '0;
      ewd[i] = '0;
      ebe[i] = '0;
      wt[i] = waits < 0 ? int'($urandom_range(0, 2)) : waits;
    end
    if (!bad) for (int k = 0; k < n; k++) begin
      ba = a + 32'(k);
      ln = int'(ba[1:0]);
      if (k == 0 || ln == 0) begin
        eaddr[nb] = {ba[31:2], 2'b00};
        nb++;
      end
      ebe[nb-1][ln] = 1'b1;
      ewd[nb-1][8*ln +: 8] = d[8*k +: 8];
      eload[8*k +: 8] = rdbyte(ba);
    end
    eb = (!bad && errb >= 0 && errb < nb) ? errb : -1;
    nbe = bad ? 0 : eb >= 0 ? eb + 1 : nb;
    efault = bad || eb >= 0;
    if (efault || we) eload = '0;
    expcyc = 1;
    for (int i = 0; i < nbe; i++) expcyc += 1 + wt[i];
    @(negedge Clock);
    ReadEnable = re;
    WriteEnable = we;
    DataWidth = w;
    MemoryAddress = a;
    DataOut = d;
    BusReady = 1'b0;
    BusError = 1'b0;
    #1;
    chk("stall_request", Stall, 1);
    chk("fault_idle", Fault, 0);
    cyc = 0;
    bi = 0;
    wc = 0;
    forever begin
      @(negedge Clock);
      cyc++;
      BusReady = 1'b0;
      BusError = 1'b0;
      if (cyc > 40) begin
        chk("timeout", cyc, expcyc);
        break;
      end
      if (BusRequest) begin
        if (bi >= nbe) begin
          chk("extra_beat", bi, nbe);
          break;
        end
        chk("beat_addr", BusAddress, eaddr[bi]);
        chk("beat_be", BusByteEnable, ebe[bi]);
        chk("beat_write", BusWrite, we);
        if (we) chk("beat_wdata", BusWriteData, ewd[bi]);
        chk("stall_busy", Stall, 1);
        if (wc == wt[bi]) begin
          BusReady = 1'b1;
          BusError = (bi == eb);
          BusReadData = rdword(eaddr[bi]);
          bi++;
          wc = 0;
        end else begin
          wc++;
          BusReadData = $urandom;
        end
      end else begin
        chk("latency", cyc, expcyc);
        chk("beat_count", bi, nbe);
        chk("stall_done", Stall, 0);
        chk("fault_done", Fault, efault);
        chk("datain", DataIn, eload);
        break;
      end
    end
  endtask

  initial begin
    logic [1:0] w;
    logic re, we;
    logic [31:0] a;
    int r, eb;
    ReadEnable = 1'b1;
    DataWidth = 2'd2;
    repeat (3) @(negedge Clock);
    chk("rst_datain", DataIn, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_busreq", BusRequest, 0);
    chk("rst_buswrite", BusWrite, 0);
    chk("rst_busaddr", BusAddress, 0);
    chk("rst_busbe", BusByteEnable, 0);
    chk("rst_buswd", BusWriteData, 0);
    chk("rst_stall", Stall, 0);
    Reset = 1'b1;
    ReadEnable = 1'b0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h10] = 32'h44332211;
    mem[32'h14] = 32'h88776655;
    txn(1, 0, 2'd2, 32'h100, 32'h0, 0, -1);
    txn(0, 1, 2'd0, 32'h203, 32'h000000A5, 0, -1);
    txn(0, 1, 2'd0, 32'h203, 32'h123456A5, 0, -1);
    txn(1, 0, 2'd2, 32'h11, 32'h0, 0, -1);
    txn(0, 1, 2'd1, 32'hFFFFFFFF, 32'h0000BBAA, 0, -1);
    txn(1, 0, 2'd2, 32'h40, 32'h0, 2, 0);
    txn(1, 0, 2'd2, 32'h13, 32'h0, 1, 1);
    txn(1, 0, 2'd3, 32'h100, 32'h0, 0, -1);
    txn(1, 1, 2'd2, 32'h100, 32'h0, 0, -1);
    @(negedge Clock);
    ReadEnable = 1'b1;
    WriteEnable = 1'b0;
    DataWidth = 2'd2;
    MemoryAddress = 32'h80;
    BusReady = 1'b0;
    BusError = 1'b0;
    @(negedge Clock);
    chk("midrst_beat", BusRequest, 1);
    Reset = 1'b0;
    @(negedge Clock);
    chk("midrst_busreq", BusRequest, 0);
    chk("midrst_stall", Stall, 0);
    chk("midrst_fault", Fault, 0);
    chk("midrst_be", BusByteEnable, 0);
    Reset = 1'b1;
    ReadEnable = 1'b0;
    txn(1, 0, 2'd1, 32'h102, 32'h0, 0, -1);
    for (int t = 0; t < 200; t++) begin
      r = int'($urandom_range(0, 19));
      w = r == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      re = r == 1 ? 1'b1 : 1'($urandom_range(0, 1));
      we = r == 1 ? 1'b1 : ~re;
      a = $urandom_range(0, 3) == 0 ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      eb = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 1)) : -1;
      txn(re, we, w, a, $urandom, -1, eb);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sol32lsu.md
# sol32lsu

Load/store unit between the sol32 core's data port and the system memory bus. It takes single-cycle load/store requests (enable, width, address, store data) and turns them into one or two word-aligned bus beats with byte enables. Misaligned accesses are split into two beats. The core is stalled until the returned load data, or the store completion, is ready.

## Interface
Parameters:
- none; data and address width fixed at 32, bus little-endian.

Ports (core side, then bus side):
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- ReadEnable  in  1  core load request
- WriteEnable  in  1  core store request
- DataWidth  in  2  00 byte, 01 half, 10 word, 11 reserved
- MemoryAddress  in  32  byte address
- DataOut  in  32  store data, right-aligned
- DataIn  out  32  load result, zero-extended, right-aligned
- Stall  out  1  core must hold instruction and request inputs stable
- Fault  out  1  one-cycle pulse, coincident with completion, on error
- BusRequest  out  1  beat valid
- BusWrite  out  1  1 = write beat
- BusAddress  out  32  word address, bits [1:0] always 00
- BusByteEnable  out  4  lane enables, bit n = bits [8n+7:8n]
- BusWriteData  out  32  lane-positioned write data
- BusReadData  in  32  read data, valid with BusReady
- BusReady  in  1  beat completes this edge
- BusError  in  1  sampled only with BusReady

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- Request = ReadEnable | WriteEnable.
- **IDLE:**
  - Request with both enables high or DataWidth = 11: latch Fault and go to DONE. No bus beat.
  - Otherwise latch address, width, store data and direction, then go to BEAT0.
- **Lane math** (off = Address[1:0]):
  - mask = 0001 / 0011 / 1111 for byte / half / word.
  - Lane vector L = mask << off, 8 bits wide.
  - Write vector W = DataOut << (8·off), 64 bits wide.
- **BEAT0:**
  - Drive BusAddress = {Addr[31:2], 00}, BusByteEnable = L[3:0], BusWriteData = W[31:0].
  - On BusReady with BusError: Fault, go to DONE.
  - On BusReady without error: capture BusReadData into low word. Go to BEAT1 if L[7:4] ≠ 0, else DONE.
- **BEAT1:**
  - Drive BusAddress = {Addr[31:2], 00} + 4. This wraps modulo 2^32, so FFFFFFFC + 4 = 00000000.
  - Drive BusByteEnable = L[7:4], BusWriteData = W[63:32].
  - On BusReady: capture into high word, set Fault if BusError, go to DONE.
- **DONE:**
  - Loads: DataIn = ({high, low} >> 8·off) masked to width, zero-extended.
  - Faulted loads and all stores: DataIn = 0.
  - Fault asserted for this cycle only. Next state IDLE.
- Stall = Reset & Request & (state ≠ DONE). Stall is combinational, so it is high in the request cycle itself.
- Bus beats hold address, lanes, data and BusWrite stable while BusRequest is high and BusReady is low.
- BusRequest deasserts on the edge that samples BusReady.
- Stores never drive unset lanes. Lanes with BusByteEnable = 0 carry 0 on BusWriteData.

## Timing
- **Reset:** while Reset = 0 at an edge, state becomes IDLE and all registered outputs clear. That covers DataIn, Fault, BusRequest, BusWrite, BusAddress, BusByteEnable and BusWriteData. Stall is 0 while Reset is low.
- **Reset mid-beat:** BusRequest drops at that edge. The pending bus beat is abandoned. Bus slaves must tolerate this.
- **Aligned access, zero-wait bus:**
  - Request in cycle N.
  - BusRequest high in N+1 with BusReady.
  - DONE in N+2, where Stall is low and the core writes back at the end of N+2.
  - Total: 3 cycles.
- **Split access:** +1 cycle per extra beat. Each bus wait state adds 1 cycle.
- **Back-to-back requests:** a request present in the IDLE cycle following DONE starts immediately. No bubble beyond DONE → IDLE.
- **Request inputs:** sampled only in IDLE. Changes during BEAT0/BEAT1 are a core protocol violation and are ignored.
- **Fault:** a fault from a width or enable error completes in 2 cycles (IDLE → DONE).

## Test plan
- **Aligned word load:** load at 00000100, BusReadData = DEADBEEF, zero-wait.
  - BusByteEnable = 1111, BusAddress = 00000100.
  - DataIn = DEADBEEF in N+2. Stall high in N and N+1 only.
- **Byte store:** store at 00000203, DataOut = 000000A5.
  - One beat: BusAddress = 00000200, BusByteEnable = 1000, BusWriteData = A5000000.
- **Misaligned word load:** load at 00000011. Beat data 44332211 then 88776655.
  - Beat lanes 1110 then 0001. Beat addresses 00000010 then 00000014.
  - DataIn = 55443322.
- **Wrap-around half store:** store at FFFFFFFF, DataOut = 0000BBAA.
  - Beat 0: FFFFFFFC, lanes 1000, data AA000000.
  - Beat 1: 00000000, lanes 0001, data 000000BB.
- **Error and wait states:**
  - Two wait states then BusReady + BusError on a word load: Fault pulses once, DataIn = 0.
  - DataWidth = 11: Fault with no BusRequest.
  - Reset low during a wait state: BusRequest 0 after that edge, state IDLE.
